approx_err_acc: RTL and testbench
=================================

APPROX_ERR_ACC -- requirements
Module: approx_err_acc

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the product width of the approximate and exact multiplier outputs.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the sample-counter width.
REQ-003 The block SHALL have a derived local parameter ACC_W = W+CNT_W, meaning the error-sum width.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, meaning the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, width 1, meaning a request to begin a run.
REQ-007 The block SHALL have port n_samples, input, width CNT_W, meaning the number of beats in a run; sampled on an accepted start.
REQ-008 The block SHALL have port abort, input, width 1, meaning a synchronous return to IDLE.
REQ-009 The block SHALL have port in_valid, input, width 1, meaning the operand pair is valid.
REQ-010 The block SHALL have port in_ready, output, width 1, meaning the block accepts a beat.
REQ-011 The block SHALL have port approx_p, input, width W, meaning the approximate (truncated) product.
REQ-012 The block SHALL have port exact_p, input, width W, meaning the exact product.
REQ-013 The block SHALL have port busy, output, width 1, meaning the state is RUN.
REQ-014 The block SHALL have port done, output, width 1, meaning the state is DONE and the results are final.
REQ-015 The block SHALL have port sae, output, width ACC_W, meaning the sum of absolute errors.
REQ-016 The block SHALL have port max_ae, output, width W, meaning the maximum absolute error.
REQ-017 The block SHALL have port err_cnt, output, width CNT_W, meaning the number of beats with a nonzero error.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 In IDLE, start=1 SHALL latch n_samples into a remaining-beat counter and clear sae, max_ae and err_cnt.
  - Next state is RUN, or DONE if n_samples=0.
REQ-020 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL equal busy.
REQ-021 For each accepted beat, the block SHALL compute ae = |approx_p - exact_p| as an unsigned W-bit value without wrap.
REQ-022 On each accepted beat, the block SHALL make the following updates, visible on the following cycle:
  - sae += ae (zero-extended to ACC_W);
  - max_ae = max(max_ae, ae);
  - err_cnt += 1 if ae != 0;
  - remaining -= 1.
REQ-023 Acceptance of the beat that brings remaining to 0 SHALL move the FSM to DONE on the same edge; done SHALL be 1 in the cycle after that beat, and the results SHALL include that beat.
REQ-024 sae SHALL never overflow, since ACC_W is sized for (2^CNT_W - 1) beats of maximum error; no saturation logic is required.
REQ-025 In DONE, the outputs SHALL hold stable and in_ready SHALL be 0.
  - start=1 behaves as it does in IDLE (restart with clear).
  - Otherwise the FSM stays in DONE.
REQ-026 start asserted in RUN SHALL be ignored.
REQ-027 in_valid asserted in IDLE or DONE SHALL be ignored, with no state change.
REQ-028 abort=1 in any state SHALL move the FSM to IDLE on the next edge and clear sae, max_ae, err_cnt and remaining.
  - abort has priority over start and over a simultaneous accepted beat.
REQ-029 in_valid=0 in RUN SHALL stall with no counter change; there is no timeout.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously force state=IDLE, sae=0, max_ae=0, err_cnt=0, remaining=0, busy=0, done=0 and in_ready=0.
REQ-031 Reset asserted mid-run SHALL discard all partial results; deassertion SHALL be synchronised externally.

Structure
REQ-032 The package approx_err_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default W and CNT_W constants.
REQ-033 The block SHALL use one sub-module, abs_diff_u: a combinational W-bit unsigned absolute difference.
REQ-034 The remaining datapath SHALL be a single registered stage in approx_err_acc, with no further hierarchy.

Verification
REQ-035 Run with n_samples=1, approx_p=16384, exact_p=65025 (8-bit k=7 truncation, a=b=255) -> done one cycle after the beat; sae=48641, max_ae=48641, err_cnt=1.
REQ-036 Run with n_samples=4 and beat pairs (0,0), (10,7), (7,10), (100,100) -> sae=6, max_ae=3, err_cnt=2.
REQ-037 Start with n_samples=0 -> DONE on the next cycle, all results 0, no beat ever accepted.
REQ-038 Run with n_samples=3, in_valid toggled 1,0,0,1,1, and start pulsed mid-run -> exactly 3 beats counted, start ignored, done after the 3rd beat.
REQ-039 Abort on the same cycle as the 2nd of 3 beats -> IDLE next cycle, all results 0; a subsequent start(n=1) runs cleanly.
REQ-040 rst_n pulled low mid-run, asynchronously to clk -> outputs 0 immediately; after release, in_ready=0 until start.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared types and default widths for the approximate-multiplier error accumulator.
package approx_err_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default product width and sample-counter width.
  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/abs_diff_u.sv
// Combinational unsigned absolute difference |a - b| without wrap-around.
module abs_diff_u #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
  end

endmodule

// File: rtl/approx_err_acc.sv
// Accumulates error statistics (sum, maximum, nonzero count) between an
// approximate and an exact product stream over a run of n_samples beats.
module approx_err_acc
  import approx_err_pkg::*;
#(
  parameter  int W     = W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int ACC_W = W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     approx_p,
  input  logic [W-1:0]     exact_p,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sae,
  output logic [W-1:0]     max_ae,
  output logic [CNT_W-1:0] err_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   sae_q, sae_d;
  logic [W-1:0]       max_q, max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       ae;
  logic               accept;

  abs_diff_u #(.W(W)) u_abs_diff (
    .a_i    (approx_p),
    .b_i    (exact_p),
    .diff_o (ae)
  );

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign in_ready = busy;
  assign accept   = in_valid && in_ready;

  assign sae     = sae_q;
  assign max_ae  = max_q;
  assign err_cnt = cnt_q;

  // Next-state and datapath update; abort overrides start and any beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sae_d   = sae_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
      sae_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            rem_d   = n_samples;
            sae_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
            state_d = (n_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            sae_d = sae_q + ACC_W'(ae);
            if (ae > max_q) max_d = ae;
            if (ae != '0)   cnt_d = cnt_q + CNT_W'(1);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Single registered stage holding control state and running results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sae_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sae_q   <= sae_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_approx_err_acc.sv
// Directed bench for approx_err_acc: table of single-beat runs plus
// hand-written multi-cycle sequences.
module tb_approx_err_acc;

  localparam int W     = 16;
  localparam int CNT_W = 16;
  localparam int ACC_W = W + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     approx_p;
  logic [W-1:0]     exact_p;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] sae;
  logic [W-1:0]     max_ae;
  logic [CNT_W-1:0] err_cnt;

  int n_chk;
  int n_fail;

  approx_err_acc #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_samples (n_samples),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .approx_p  (approx_p),
    .exact_p   (exact_p),
    .busy      (busy),
    .done      (done),
    .sae       (sae),
    .max_ae    (max_ae),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     e;
    logic [ACC_W-1:0] sae;
    logic [W-1:0]     mx;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    n_samples = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] e);
    in_valid = 1'b1;
    approx_p = a;
    exact_p  = e;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [ACC_W-1:0] s,
                         input logic [W-1:0] m, input logic [CNT_W-1:0] c);
    chk({tag, ".sae"},     64'(sae),     64'(s));
    chk({tag, ".max_ae"},  64'(max_ae),  64'(m));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(c));
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    n_samples = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    approx_p  = '0;
    exact_p   = '0;

    vecs[0] = '{a: 16'd16384, e: 16'd65025, sae: 32'd48641, mx: 16'd48641, cnt: 16'd1};
    vecs[1] = '{a: 16'd0,     e: 16'd0,     sae: 32'd0,     mx: 16'd0,     cnt: 16'd0};
    vecs[2] = '{a: 16'd65535, e: 16'd0,     sae: 32'd65535, mx: 16'd65535, cnt: 16'd1};
    vecs[3] = '{a: 16'd0,     e: 16'd65535, sae: 32'd65535, mx: 16'd65535, cnt: 16'd1};
    vecs[4] = '{a: 16'd1234,  e: 16'd1230,  sae: 32'd4,     mx: 16'd4,     cnt: 16'd1};
    vecs[5] = '{a: 16'd77,    e: 16'd77,    sae: 32'd0,     mx: 16'd0,     cnt: 16'd0};

    // Reset state
    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk_res("rst", '0, '0, '0);
    rst_n = 1'b1;
    tick();

    // Single-beat runs from the table
    for (int i = 0; i < 6; i++) begin
      do_start(16'd1);
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'd1);
      chk_res($sformatf("v%0d.clr", i), '0, '0, '0);
      beat(vecs[i].a, vecs[i].e);
      chk($sformatf("v%0d.done", i), 64'(done), 64'd1);
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'd0);
      chk_res($sformatf("v%0d", i), vecs[i].sae, vecs[i].mx, vecs[i].cnt);
    end

    // Four-beat run with mixed errors
    do_start(16'd4);
    beat(16'd0, 16'd0);
    beat(16'd10, 16'd7);
    beat(16'd7, 16'd10);
    chk("r4.done_early", 64'(done), 64'd0);
    beat(16'd100, 16'd100);
    chk("r4.done", 64'(done), 64'd1);
    chk_res("r4", 32'd6, 16'd3, 16'd2);
    // Results hold in DONE
    tick();
    tick();
    chk("r4.hold_done", 64'(done), 64'd1);
    chk_res("r4.hold", 32'd6, 16'd3, 16'd2);

    // Zero-length run; in_valid while DONE is ignored
    do_start(16'd0);
    chk("n0.done", 64'(done), 64'd1);
    chk("n0.busy", 64'(busy), 64'd0);
    chk("n0.in_ready", 64'(in_ready), 64'd0);
    chk_res("n0", '0, '0, '0);
    beat(16'd50, 16'd1);
    chk_res("n0.ign", '0, '0, '0);
    chk("n0.still_done", 64'(done), 64'd1);

    // Stalls and start ignored while running
    do_start(16'd3);
    beat(16'd5, 16'd2);
    tick();
    chk_res("stall", 32'd3, 16'd3, 16'd1);
    start     = 1'b1;
    n_samples = 16'd9;
    tick();
    start     = 1'b0;
    chk("stall.busy", 64'(busy), 64'd1);
    chk_res("stall.start_ign", 32'd3, 16'd3, 16'd1);
    beat(16'd2, 16'd4);
    chk("stall.done_early", 64'(done), 64'd0);
    beat(16'd9, 16'd9);
    chk("stall.done", 64'(done), 64'd1);
    chk_res("stall.fin", 32'd5, 16'd3, 16'd2);

    // Abort coincident with the second of three beats
    do_start(16'd3);
    beat(16'd3, 16'd1);
    abort = 1'b1;
    beat(16'd8, 16'd1);
    abort = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk_res("abort", '0, '0, '0);
    do_start(16'd1);
    beat(16'd6, 16'd9);
    chk("abort.rerun_done", 64'(done), 64'd1);
    chk_res("abort.rerun", 32'd3, 16'd3, 16'd1);

    // Asynchronous reset mid-run
    do_start(16'd2);
    beat(16'd20, 16'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.in_ready", 64'(in_ready), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk_res("arst", '0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst.idle_ready", 64'(in_ready), 64'd0);
    chk("arst.idle_busy", 64'(busy), 64'd0);
    do_start(16'd1);
    beat(16'd1, 16'd2);
    chk("arst.rerun_done", 64'(done), 64'd1);
    chk_res("arst.rerun", 32'd1, 16'd1, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
